// File: rtl/score_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter for the score display.
// Re-converts whenever the score changes and drives a leading-zero blank mask.
module score_bcd_converter #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic [WIDTH-1:0]  score,
   output logic [3:0]        hex_num_0,
   output logic [3:0]        hex_num_1,
   output logic [3:0]        hex_num_2,
   output logic [3:0]        hex_num_3,
   output logic [3:0]        hex_num_4,
   output logic [DIGITS-1:0] blank,
   output logic              busy,
   output logic              done
);

   localparam int BCDW = 4 * DIGITS;
   localparam int SRW  = BCDW + WIDTH;
   localparam int CNTW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Double-dabble correction: every nibble holding 5..9 gets +3 before the shift.
   function automatic logic [BCDW-1:0] add3_all(input logic [BCDW-1:0] bcd);
      logic [BCDW-1:0] r;
      r = bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (r[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd3;
         end else begin
            r[4*i +: 4] = r[4*i +: 4];
         end
      end
      return r;
   endfunction

   // Digit i is blanked only when it and every higher digit are zero; digit 0 always shows.
   function automatic logic [DIGITS-1:0] lz_mask(input logic [BCDW-1:0] bcd);
      logic [DIGITS-1:0] m;
      logic              all_zero;
      m        = '0;
      all_zero = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         all_zero = all_zero & (bcd[4*i +: 4] == 4'd0);
         m[i]     = all_zero;
      end
      m[0] = 1'b0;
      return m;
   endfunction

   state_t            state_q;
   logic [CNTW-1:0]   cnt_q;
   logic [SRW-1:0]    shift_q;
   logic [SRW-1:0]    shift_adj_s;
   logic [SRW-1:0]    shift_d;
   logic [WIDTH-1:0]  last_score_q;
   logic [BCDW-1:0]   hex_q;
   logic [DIGITS-1:0] blank_q;
   logic              busy_q;
   logic              done_q;

   // Next value of the shift register for one double-dabble step.
   always_comb begin
      shift_adj_s = {add3_all(shift_q[SRW-1 -: BCDW]), shift_q[WIDTH-1:0]};
      shift_d     = {shift_adj_s[SRW-2:0], 1'b0};
   end

   // Conversion FSM; display registers only change in DONE so no partial result is shown.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         shift_q      <= '0;
         last_score_q <= '0;
         hex_q        <= '0;
         blank_q      <= {{(DIGITS-1){1'b1}}, 1'b0};
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (score != last_score_q) begin
                  shift_q      <= {{BCDW{1'b0}}, score};
                  last_score_q <= score;
                  cnt_q        <= '0;
                  busy_q       <= 1'b1;
                  state_q      <= ST_SHIFT;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            ST_SHIFT: begin
               shift_q <= shift_d;
               cnt_q   <= cnt_q + CNTW'(1);
               busy_q  <= 1'b1;
               if (cnt_q == CNTW'(WIDTH - 1)) begin
                  state_q <= ST_DONE;
               end else begin
                  state_q <= ST_SHIFT;
               end
            end
            ST_DONE: begin
               hex_q   <= shift_q[SRW-1 -: BCDW];
               blank_q <= lz_mask(shift_q[SRW-1 -: BCDW]);
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign hex_num_0 = hex_q[3:0];
   assign hex_num_1 = hex_q[7:4];
   assign hex_num_2 = hex_q[11:8];
   assign hex_num_3 = hex_q[15:12];
   assign hex_num_4 = hex_q[19:16];
   assign blank     = blank_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_score_bcd_converter.sv
// Bench for score_bcd_converter: decimal-arithmetic reference model checked every cycle,
// directed scenarios with hand-computed values, then randomized score traffic.
module tb_score_bcd_converter;

   logic        Clk;
   logic        Reset_n;
   logic [15:0] score;
   logic [3:0]  hex_num_0, hex_num_1, hex_num_2, hex_num_3, hex_num_4;
   logic [4:0]  blank;
   logic        busy;
   logic        done;

   int n_tests = 0;
   int n_fail  = 0;
   int done_cnt = 0;

   // Reference model: conversion latched at sampling, result visible 17 edges later.
   int m_rem  = 0;
   int m_last = 0;
   int m_pend = 0;
   int m_disp = 0;
   bit m_done = 1'b0;

   score_bcd_converter #(.WIDTH(16), .DIGITS(5)) dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .score     (score),
      .hex_num_0 (hex_num_0),
      .hex_num_1 (hex_num_1),
      .hex_num_2 (hex_num_2),
      .hex_num_3 (hex_num_3),
      .hex_num_4 (hex_num_4),
      .blank     (blank),
      .busy      (busy),
      .done      (done)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic logic [19:0] exp_bcd(input int v);
      logic [19:0] r;
      int p;
      r = 20'd0;
      p = 1;
      for (int i = 0; i < 5; i++) begin
         r[4*i +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   function automatic logic [4:0] exp_blank(input int v);
      logic [4:0] b;
      int p;
      b = 5'd0;
      p = 10;
      for (int i = 1; i < 5; i++) begin
         b[i] = (v < p);
         p = p * 10;
      end
      return b;
   endfunction

   function automatic logic [19:0] dut_bcd();
      return {hex_num_4, hex_num_3, hex_num_2, hex_num_1, hex_num_0};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic wait_done(output int c);
      c = 0;
      do begin
         @(negedge Clk);
         c++;
      end while (done !== 1'b1 && c < 60);
      check("done_seen", {31'd0, done}, 32'd1);
   endtask

   // Per-cycle comparison against the model, just after each rising edge.
   initial begin
      forever begin
         @(posedge Clk);
         if (!Reset_n) begin
            m_rem = 0; m_last = 0; m_pend = 0; m_disp = 0; m_done = 1'b0;
         end else begin
            m_done = 1'b0;
            if (m_rem == 0) begin
               if (int'(score) != m_last) begin
                  m_last = int'(score);
                  m_pend = int'(score);
                  m_rem  = 17;
               end
            end else begin
               m_rem--;
               if (m_rem == 0) begin
                  m_disp = m_pend;
                  m_done = 1'b1;
               end
            end
         end
         #2;
         check("cyc_digits", {12'd0, dut_bcd()}, {12'd0, exp_bcd(m_disp)});
         check("cyc_blank", {27'd0, blank}, {27'd0, exp_blank(m_disp)});
         check("cyc_busy", {31'd0, busy}, {31'd0, (m_rem > 0)});
         check("cyc_done", {31'd0, done}, {31'd0, m_done});
         if (done === 1'b1) done_cnt++;
      end
   end

   initial begin
      int c;
      int d0;
      Reset_n = 1'b0;
      score   = 16'd0;
      repeat (3) @(negedge Clk);
      Reset_n = 1'b1;

      // Idle at score 0: nothing converts.
      repeat (50) @(negedge Clk);
      check("rst_digits", {12'd0, dut_bcd()}, 32'h0);
      check("rst_blank", {27'd0, blank}, 32'h1E);
      check("rst_done_cnt", done_cnt, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);

      score = 16'd1234;
      @(negedge Clk);
      check("busy_1234", {31'd0, busy}, 32'd1);
      wait_done(c);
      check("lat_1234", c, 32'd17);
      check("dig_1234", {12'd0, dut_bcd()}, 32'h01234);
      check("blank_1234", {27'd0, blank}, 32'h10);
      @(negedge Clk);
      check("done_pulse_1234", {31'd0, done}, 32'd0);

      score = 16'd65535;
      wait_done(c);
      check("dig_65535", {12'd0, dut_bcd()}, 32'h65535);
      check("blank_65535", {27'd0, blank}, 32'h00);
      score = 16'd7;
      wait_done(c);
      check("dig_7", {12'd0, dut_bcd()}, 32'h00007);
      check("blank_7", {27'd0, blank}, 32'h1E);

      // Score changes mid-conversion.
      score = 16'd100;
      repeat (5) @(negedge Clk);
      score = 16'd9999;
      wait_done(c);
      check("lat_100", c, 32'd13);
      check("dig_100", {12'd0, dut_bcd()}, 32'h00100);
      wait_done(c);
      check("lat_9999", c, 32'd18);
      check("dig_9999", {12'd0, dut_bcd()}, 32'h09999);

      score = 16'd42;
      wait_done(c);
      d0 = done_cnt;
      repeat (100) @(negedge Clk);
      check("hold_42_pulses", done_cnt - d0, 32'd0);
      check("dig_42", {12'd0, dut_bcd()}, 32'h00042);

      // Asynchronous reset mid-SHIFT.
      score = 16'd500;
      repeat (6) @(negedge Clk);
      @(posedge Clk);
      #3 Reset_n = 1'b0;
      #1;
      check("arst_digits", {12'd0, dut_bcd()}, 32'h0);
      check("arst_blank", {27'd0, blank}, 32'h1E);
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_done", {31'd0, done}, 32'd0);
      @(negedge Clk);
      @(negedge Clk);
      Reset_n = 1'b1;
      wait_done(c);
      check("lat_500", c, 32'd18);
      check("dig_500", {12'd0, dut_bcd()}, 32'h00500);

      // Randomized traffic, including equal writes and mid-conversion changes.
      repeat (300) begin
         case ($urandom % 5)
            0: score = score;
            1: score = 16'($urandom % 100);
            2: score = 16'($urandom % 65536);
            3: score = ($urandom % 2 == 0) ? 16'd0 : 16'd65535;
            default: score = 16'($urandom % 10000);
         endcase
         repeat ($urandom_range(1, 40)) @(negedge Clk);
      end
      repeat (60) @(negedge Clk);
      check("final_digits", {12'd0, dut_bcd()}, {12'd0, exp_bcd(int'(score))});
      check("final_blank", {27'd0, blank}, {27'd0, exp_blank(int'(score))});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
